// File: rtl/sr_chk_pkg.sv
// Shared types and constants for the PRBS-7 shift-register checker.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // PRBS-7, polynomial x^7 + x^6 + 1; history bit 0 is the newest sample.
    localparam int PRBS_ORDER = 7;
    localparam int TAP_A      = 6;
    localparam int TAP_B      = 5;

    // Next expected bit from the last PRBS_ORDER received bits.
    function automatic logic prbs_predict(input logic [PRBS_ORDER-1:0] hist);
        return hist[TAP_A] ^ hist[TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_r;

    // Count register: reset/clear to zero, otherwise increment until all-ones and hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r <= '0;
        end else if (clr) begin
            value_r <= '0;
        end else if (inc && (value_r != {WIDTH{1'b1}})) begin
            value_r <= value_r + WIDTH'(1);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/sr_prbs_checker.sv
// Self-synchronising PRBS-7 checker for the serial output of the latch shift register.
// Hunts for 7 bits of history, verifies LOCK_BITS consecutive predictions, then
// free-runs its own predictor (flywheel) and counts mismatches and checked bits.
module sr_prbs_checker #(
    parameter int ERR_W     = 8,
    parameter int BIT_W     = 16,
    parameter int LOCK_BITS = 16,
    parameter int WIN_LEN   = 64,
    parameter int LOSS_ERRS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sr_bit,
    input  logic             en,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BIT_W-1:0] bit_count
);

    import sr_chk_pkg::*;

    localparam int FILL_W = $clog2(PRBS_ORDER);
    localparam int GOOD_W = $clog2(LOCK_BITS + 1);
    localparam int WIN_W  = $clog2(WIN_LEN + 1);
    localparam int LERR_W = $clog2(LOSS_ERRS + 1);

    chk_state_t              state_r, state_s;
    logic [PRBS_ORDER-1:0]   hist_r, hist_s;
    logic [FILL_W-1:0]       fill_r, fill_s;
    logic [GOOD_W-1:0]       good_r, good_s;
    logic [WIN_W-1:0]        win_cnt_r, win_cnt_s;
    logic [LERR_W-1:0]       win_err_r, win_err_s;
    logic                    err_pulse_r, err_pulse_s;
    logic                    locked_r;

    logic                    predict_s;
    logic                    mismatch_s;
    logic                    err_inc_s;
    logic                    bit_inc_s;
    logic [GOOD_W-1:0]       good_plus_s;
    logic [WIN_W-1:0]        win_plus_s;
    logic [LERR_W-1:0]       win_err_plus_s;

    assign predict_s      = prbs_predict(hist_r);
    assign mismatch_s     = sr_bit ^ predict_s;
    assign good_plus_s    = good_r + GOOD_W'(1);
    assign win_plus_s     = win_cnt_r + WIN_W'(1);
    assign win_err_plus_s = win_err_r + LERR_W'(1);

    // Next-state logic: hunt/verify/locked sequencing, history update and window bookkeeping.
    always_comb begin
        state_s     = state_r;
        hist_s      = hist_r;
        fill_s      = fill_r;
        good_s      = good_r;
        win_cnt_s   = win_cnt_r;
        win_err_s   = win_err_r;
        err_pulse_s = 1'b0;
        err_inc_s   = 1'b0;
        bit_inc_s   = 1'b0;
        if (en) begin
            case (state_r)
                HUNT: begin
                    hist_s = {hist_r[PRBS_ORDER-2:0], sr_bit};
                    if (fill_r == FILL_W'(PRBS_ORDER - 1)) begin
                        fill_s  = '0;
                        good_s  = '0;
                        state_s = VERIFY;
                    end else begin
                        fill_s = fill_r + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    hist_s = {hist_r[PRBS_ORDER-2:0], sr_bit};
                    // An all-zero history predicts zero forever; never credit it.
                    if (!mismatch_s && (hist_r != '0)) begin
                        if (good_plus_s == GOOD_W'(LOCK_BITS)) begin
                            state_s   = LOCKED;
                            good_s    = '0;
                            win_cnt_s = '0;
                            win_err_s = '0;
                        end else begin
                            good_s = good_plus_s;
                        end
                    end else begin
                        good_s = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: feed our own prediction back so a bad bit cannot poison history.
                    hist_s      = {hist_r[PRBS_ORDER-2:0], predict_s};
                    bit_inc_s   = 1'b1;
                    err_inc_s   = mismatch_s;
                    err_pulse_s = mismatch_s;
                    if (mismatch_s && (win_err_plus_s == LERR_W'(LOSS_ERRS))) begin
                        state_s   = HUNT;
                        fill_s    = '0;
                        good_s    = '0;
                        win_cnt_s = '0;
                        win_err_s = '0;
                    end else if (win_plus_s == WIN_W'(WIN_LEN)) begin
                        win_cnt_s = '0;
                        win_err_s = '0;
                    end else begin
                        win_cnt_s = win_plus_s;
                        win_err_s = mismatch_s ? win_err_plus_s : win_err_r;
                    end
                end
                default: begin
                    state_s   = HUNT;
                    fill_s    = '0;
                    good_s    = '0;
                    win_cnt_s = '0;
                    win_err_s = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= HUNT;
            hist_r      <= '0;
            fill_r      <= '0;
            good_r      <= '0;
            win_cnt_r   <= '0;
            win_err_r   <= '0;
            err_pulse_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            hist_r      <= hist_s;
            fill_r      <= fill_s;
            good_r      <= good_s;
            win_cnt_r   <= win_cnt_s;
            win_err_r   <= win_err_s;
            err_pulse_r <= err_pulse_s;
            locked_r    <= (state_s == LOCKED);
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_cnt),
        .inc   (err_inc_s),
        .value (err_count)
    );

    sat_counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_cnt),
        .inc   (bit_inc_s),
        .value (bit_count)
    );

    assign locked    = locked_r;
    assign err_pulse = err_pulse_r;

endmodule

// File: tb/tb_sr_prbs_checker.sv
// Scoreboard bench for sr_prbs_checker: stimulus pushes expected outputs tagged with
// the clock edge they apply after; a negedge monitor pops and compares them.
module tb_sr_prbs_checker;

    logic        clk;
    logic        rst_n;
    logic        sr_bit;
    logic        en;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [15:0] bit_count;

    sr_prbs_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sr_bit    (sr_bit),
        .en        (en),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    typedef struct {
        string       name;
        int          due;
        logic        lk;
        logic        pl;
        logic [7:0]  ec;
        logic [15:0] bc;
    } exp_t;

    exp_t       q[$];
    int         edges  = 0;
    int         checks = 0;
    int         passes = 0;
    logic [6:0] gen;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time-tag expectations.
    always @(posedge clk) edges = edges + 1;

    // Monitor: compare every expectation due at the edge just taken.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= edges) begin
            exp_t e;
            e = q.pop_front();
            checks = checks + 1;
            if (e.due != edges || locked !== e.lk || err_pulse !== e.pl ||
                err_count !== e.ec || bit_count !== e.bc) begin
                $display("FAIL %s edge=%0d(due %0d) got lk=%b pl=%b ec=%0d bc=%0d required lk=%b pl=%b ec=%0d bc=%0d",
                         e.name, edges, e.due, locked, err_pulse, err_count, bit_count,
                         e.lk, e.pl, e.ec, e.bc);
            end else begin
                passes = passes + 1;
            end
        end
    end

    // Reference PRBS-7 source: b[n] = b[n-7] ^ b[n-6].
    function automatic logic prbs_next();
        logic o;
        o   = gen[6] ^ gen[5];
        gen = {gen[5:0], o};
        return o;
    endfunction

    task automatic push_exp(input string n, input logic lk, input logic pl,
                            input logic [7:0] ec, input logic [15:0] bc);
        exp_t e;
        e.name = n;
        e.due  = edges + 1;
        e.lk   = lk;
        e.pl   = pl;
        e.ec   = ec;
        e.bc   = bc;
        q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push_exp("reset", 1'b0, 1'b0, 8'd0, 16'd0);
        step();
        rst_n = 1'b1;
    endtask

    // 23 clean samples from HUNT; lock must appear exactly after the 23rd.
    task automatic clean_lock(input string n, input logic [7:0] ec, input logic [15:0] bc);
        for (int i = 1; i <= 23; i++) begin
            sr_bit = prbs_next();
            if (i == 22) push_exp({n, "_pre"}, 1'b0, 1'b0, ec, bc);
            if (i == 23) push_exp(n, 1'b1, 1'b0, ec, bc);
            step();
        end
    endtask

    initial begin
        logic b;
        int   ev;
        rst_n     = 1'b0;
        en        = 1'b0;
        sr_bit    = 1'b0;
        clear_cnt = 1'b0;
        gen       = 7'h7F;

        push_exp("reset0", 1'b0, 1'b0, 8'd0, 16'd0);
        step();
        do_reset();
        en = 1'b1;

        // All-zero stream must never lock.
        for (int i = 0; i < 300; i++) begin
            sr_bit = 1'b0;
            push_exp("zero_stream", 1'b0, 1'b0, 8'd0, 16'd0);
            step();
        end

        // Clean lock from reset, then 10 checked bits.
        do_reset();
        clean_lock("clean_lock", 8'd0, 16'd0);
        for (int i = 1; i <= 10; i++) begin
            sr_bit = prbs_next();
            if (i == 10) push_exp("bits10", 1'b1, 1'b0, 8'd0, 16'd10);
            step();
        end

        // Single error while locked.
        b = prbs_next();
        sr_bit = ~b;
        push_exp("err1", 1'b1, 1'b1, 8'd1, 16'd11);
        step();
        sr_bit = prbs_next();
        push_exp("err1_next", 1'b1, 1'b0, 8'd1, 16'd12);
        step();
        for (int i = 1; i <= 5; i++) begin
            sr_bit = prbs_next();
            if (i == 5) push_exp("err1_tail", 1'b1, 1'b0, 8'd1, 16'd17);
            step();
        end

        // Loss of lock: 4 errors in 7 checked bits, then relock.
        do_reset();
        clean_lock("lock2", 8'd0, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            b = prbs_next();
            sr_bit = (i % 2 == 1) ? ~b : b;
            if (i == 6) push_exp("pre_loss", 1'b1, 1'b0, 8'd3, 16'd6);
            if (i == 7) push_exp("loss", 1'b0, 1'b1, 8'd4, 16'd7);
            step();
        end
        clean_lock("relock", 8'd4, 16'd7);

        // 3 errors per 64-bit window for 90 windows: err_count saturates, lock holds.
        for (int k = 1; k <= 90; k++) begin
            for (int j = 0; j < 64; j++) begin
                b = prbs_next();
                sr_bit = (j == 0 || j == 10 || j == 20) ? ~b : b;
                if (j == 63) begin
                    ev = 4 + 3 * k;
                    if (ev > 255) ev = 255;
                    push_exp("sat_window", 1'b1, 1'b0, 8'(ev), 16'(7 + 64 * k));
                end
                step();
            end
        end

        // Clear together with an error: clear wins, pulse still fires.
        b = prbs_next();
        sr_bit    = ~b;
        clear_cnt = 1'b1;
        push_exp("clear_with_err", 1'b1, 1'b1, 8'd0, 16'd0);
        step();
        clear_cnt = 1'b0;
        sr_bit = prbs_next();
        push_exp("after_clear", 1'b1, 1'b0, 8'd0, 16'd1);
        step();

        // Enable low: nothing moves, even with garbage on sr_bit.
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sr_bit = (i % 3 == 0) ? 1'b1 : 1'b0;
            push_exp("en_off", 1'b1, 1'b0, 8'd0, 16'd1);
            step();
        end
        en = 1'b1;
        sr_bit = prbs_next();
        push_exp("en_resume", 1'b1, 1'b0, 8'd0, 16'd2);
        step();

        // Reset while locked drops everything; relock needs 23 samples.
        sr_bit = prbs_next();
        do_reset();
        clean_lock("relock_after_rst", 8'd0, 16'd0);

        en = 1'b0;
        for (int i = 0; i < 3; i++) step();

        checks = checks + 1;
        if (q.size() != 0) begin
            $display("FAIL queue_drain pending=%0d required=0", q.size());
        end else begin
            passes = passes + 1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
